// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single write port of the 8x16 register file between two
// writeback requesters (A = ALU, B = memory/load) with round-robin
// arbitration, and keeps a per-register busy scoreboard so the issue
// stage stalls on RAW/WAW hazards against writes still in flight.
//
// Handshake: a requester raises valid with dr/data and holds all three
// stable until it sees ready; a transfer happens on the rising edge where
// valid && ready. ready is combinational and at most one is high per cycle.
//
// Optional feature: define WB_CONFLICT_CNT_EN to add the 16-bit saturating
// conflict_cnt output, counting cycles where both requesters are valid.
module regfile_wb_arbiter #(
   parameter int NREG = 8,
   parameter int AW   = 3,
   parameter int DW   = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            a_valid,
   output logic            a_ready,
   input  logic [AW-1:0]   a_dr,
   input  logic [DW-1:0]   a_data,
   input  logic            b_valid,
   output logic            b_ready,
   input  logic [AW-1:0]   b_dr,
   input  logic [DW-1:0]   b_data,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_dr,
   input  logic [AW-1:0]   iss_sr1,
   input  logic [AW-1:0]   iss_sr2,
   output logic            iss_stall,
   output logic            rf_ld,
   output logic [AW-1:0]   rf_dr,
   output logic [DW-1:0]   rf_din,
   output logic [NREG-1:0] busy
`ifdef WB_CONFLICT_CNT_EN
   ,
   output logic [15:0]     conflict_cnt
`endif
);

   // Encoding of the last requester served.
   localparam logic GNT_A = 1'b0;
   localparam logic GNT_B = 1'b1;

   logic            last_grant_q, last_grant_d;
   logic            rf_ld_q,      rf_ld_d;
   logic [AW-1:0]   rf_dr_q,      rf_dr_d;
   logic [DW-1:0]   rf_din_q,     rf_din_d;
   logic [NREG-1:0] busy_q,       busy_d;
   logic            gnt_a,        gnt_b;

   // Round-robin grant; on a conflict the requester not served last wins.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (rst_n) begin
         if (a_valid && (!b_valid || (last_grant_q == GNT_B))) begin
            gnt_a = 1'b1;
         end else if (b_valid) begin
            gnt_b = 1'b1;
         end
      end
   end

   assign a_ready = gnt_a;
   assign b_ready = gnt_b;

   // Hazard check has no bypass: a register being written this cycle still stalls.
   assign iss_stall = iss_valid & (busy_q[iss_sr1] | busy_q[iss_sr2] | busy_q[iss_dr]);

   // Write port next state: load the winner, otherwise hold dr/din and drop ld.
   always_comb begin
      rf_ld_d      = gnt_a | gnt_b;
      rf_dr_d      = rf_dr_q;
      rf_din_d     = rf_din_q;
      last_grant_d = last_grant_q;
      if (gnt_a) begin
         rf_dr_d      = a_dr;
         rf_din_d     = a_data;
         last_grant_d = GNT_A;
      end else if (gnt_b) begin
         rf_dr_d      = b_dr;
         rf_din_d     = b_data;
         last_grant_d = GNT_B;
      end
   end

   // Scoreboard next state: clear first, then set, so a same-register set wins.
   always_comb begin
      busy_d = busy_q;
      if (rf_ld_q) begin
         busy_d[rf_dr_q] = 1'b0;
      end
      if (iss_valid && !iss_stall) begin
         busy_d[iss_dr] = 1'b1;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant_q <= GNT_B;
         rf_ld_q      <= 1'b0;
         rf_dr_q      <= '0;
         rf_din_q     <= '0;
         busy_q       <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         rf_ld_q      <= rf_ld_d;
         rf_dr_q      <= rf_dr_d;
         rf_din_q     <= rf_din_d;
         busy_q       <= busy_d;
      end
   end

   assign rf_ld  = rf_ld_q;
   assign rf_dr  = rf_dr_q;
   assign rf_din = rf_din_q;
   assign busy   = busy_q;

`ifdef WB_CONFLICT_CNT_EN
   logic [15:0] conflict_cnt_q, conflict_cnt_d;

   // Saturating count of cycles with both requesters valid.
   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (a_valid && b_valid && (conflict_cnt_q != 16'hFFFF)) begin
         conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
   end

   // Conflict counter register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         conflict_cnt_q <= '0;
      end else begin
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by random
// traffic, all checked against a behavioural model of the arbiter rules.
module tb_regfile_wb_arbiter;

   localparam int NREG = 8;
   localparam int AW   = 3;
   localparam int DW   = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n = 1'b0;
   logic            a_valid = 1'b0, b_valid = 1'b0, iss_valid = 1'b0;
   logic [AW-1:0]   a_dr = '0, b_dr = '0, iss_dr = '0, iss_sr1 = '0, iss_sr2 = '0;
   logic [DW-1:0]   a_data = '0, b_data = '0;
   logic            a_ready, b_ready, iss_stall, rf_ld;
   logic [AW-1:0]   rf_dr;
   logic [DW-1:0]   rf_din;
   logic [NREG-1:0] busy;
`ifdef WB_CONFLICT_CNT_EN
   logic [15:0]     conflict_cnt;
`endif

   regfile_wb_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_dr(a_dr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_dr(b_dr), .b_data(b_data),
      .iss_valid(iss_valid), .iss_dr(iss_dr), .iss_sr1(iss_sr1), .iss_sr2(iss_sr2),
      .iss_stall(iss_stall), .rf_ld(rf_ld), .rf_dr(rf_dr), .rf_din(rf_din),
      .busy(busy)
`ifdef WB_CONFLICT_CNT_EN
      , .conflict_cnt(conflict_cnt)
`endif
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Behavioural model state.
   typedef struct {
      logic [AW-1:0] dr;
      logic [DW-1:0] data;
   } wb_t;
   wb_t             exp_q[$];       // writes accepted, awaiting their rf_ld cycle
   int              m_last = 1;     // 0: A served last, 1: B served last
   logic [NREG-1:0] m_busy = '0;
   logic [AW-1:0]   m_dr   = '0;
   logic [DW-1:0]   m_din  = '0;
   int              m_cnt  = 0;
   logic            g_a, g_b;       // grants predicted in the last step

   // One clock cycle: drive inputs, check every output, advance the model.
   task automatic step(input logic rst, input logic av, input logic [AW-1:0] adr,
                       input logic [DW-1:0] adat, input logic bv, input logic [AW-1:0] bdr,
                       input logic [DW-1:0] bdat, input logic iv, input logic [AW-1:0] idr,
                       input logic [AW-1:0] is1, input logic [AW-1:0] is2);
      logic ea, eb, es, eld;
      wb_t  w;
      @(negedge clk);
      rst_n = rst; a_valid = av; a_dr = adr; a_data = adat;
      b_valid = bv; b_dr = bdr; b_data = bdat;
      iss_valid = iv; iss_dr = idr; iss_sr1 = is1; iss_sr2 = is2;
      #1;
      ea = rst && av && (!bv || m_last == 1);
      eb = rst && bv && (!av || m_last == 0);
      es = iv && (m_busy[is1] || m_busy[is2] || m_busy[idr]);
      check_val("a_ready", a_ready, ea);
      check_val("b_ready", b_ready, eb);
      check_val("iss_stall", iss_stall, es);
      eld = (exp_q.size() > 0);
      check_val("rf_ld", rf_ld, eld);
      if (eld) begin
         w = exp_q.pop_front();
         m_dr = w.dr;
         m_din = w.data;
      end
      check_val("rf_dr", rf_dr, m_dr);
      check_val("rf_din", rf_din, m_din);
      check_val("busy", busy, m_busy);
`ifdef WB_CONFLICT_CNT_EN
      check_val("conflict_cnt", conflict_cnt, m_cnt);
`endif
      g_a = ea;
      g_b = eb;
      if (!rst) begin
         exp_q.delete();
         m_busy = '0; m_last = 1; m_dr = '0; m_din = '0; m_cnt = 0;
      end else begin
         if (eld) m_busy[m_dr] = 1'b0;
         if (iv && !es) m_busy[idr] = 1'b1;
         if (ea) begin
            w.dr = adr; w.data = adat; exp_q.push_back(w); m_last = 0;
         end
         if (eb) begin
            w.dr = bdr; w.data = bdat; exp_q.push_back(w); m_last = 1;
         end
         if (av && bv && m_cnt < 65535) m_cnt++;
      end
   endtask

   task automatic idle(input logic rst);
      step(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Hard time limit so the run always ends.
   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic          ra_v, rb_v;
      logic [AW-1:0] ra_dr, rb_dr;
      logic [DW-1:0] ra_d, rb_d;
      logic [3:0]    gseq;
      logic [AW-1:0] dseq[4];

      idle(0); idle(0);
      check_val("reset_rf_ld", rf_ld, 0);
      check_val("reset_busy", busy, 0);

      // A only.
      step(1, 1, 3, 16'h1234, 0, 0, 0, 0, 0, 0, 0);
      check_val("a_only_ready", a_ready, 1);
      idle(1);
      check_val("a_only_ld", rf_ld, 1);
      check_val("a_only_dr", rf_dr, 3);
      check_val("a_only_din", rf_din, 16'h1234);
      idle(1);
      check_val("a_only_ld_drop", rf_ld, 0);

      // Conflict fairness from a fresh reset (last grant = B).
      idle(0);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            step(1, 1, 1, 16'hAAAA, 1, 2, 16'hBBBB, 0, 0, 0, 0);
            gseq[i] = a_ready;
         end else begin
            idle(1);
         end
         if (i >= 1) dseq[i-1] = rf_dr;
      end
      check_val("fair_grants", gseq, 4'b0101);
      check_val("fair_dr_seq", {dseq[0], dseq[1], dseq[2], dseq[3]}, {3'd1, 3'd2, 3'd1, 3'd2});
`ifdef WB_CONFLICT_CNT_EN
      check_val("fair_conflict_cnt", conflict_cnt, 4);
`endif
      idle(1);

      // RAW on R5 resolved by a B writeback.
      step(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0);
      check_val("raw_stall", iss_stall, 1);
      step(1, 0, 0, 0, 1, 5, 16'h5555, 1, 0, 5, 0);
      check_val("raw_b_ready", b_ready, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0);
      check_val("raw_stall_during_write", iss_stall, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0);
      check_val("raw_stall_released", iss_stall, 0);
      check_val("raw_busy5_clear", busy[5], 0);

      // Same-register set and clear on one edge: set wins.
      step(1, 1, 4, 16'h4444, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 1, 4, 1, 2);
      check_val("collide_no_stall", iss_stall, 0);
      idle(1);
      check_val("collide_busy4", busy[4], 1);

      // WAW on R6 (first retire the pending R0 write).
      step(1, 1, 0, 16'h0F0F, 0, 0, 0, 1, 6, 1, 2);
      idle(1);
      step(1, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
      check_val("waw_stall", iss_stall, 1);
      idle(1);
      check_val("waw_busy", busy, 8'h50);

      // Reset in the middle of a write.
      step(1, 1, 7, 16'h7777, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 3, 16'h3333, 0, 0, 0, 0);
      check_val("rst_mid_b_ready", b_ready, 0);
      step(1, 0, 0, 0, 1, 3, 16'h3333, 0, 0, 0, 0);
      check_val("rst_mid_ld", rf_ld, 0);
      check_val("rst_mid_busy", busy, 0);
      check_val("rst_mid_b_first", b_ready, 1);
      idle(1); idle(1);

      // Random traffic; requesters hold their request until granted.
      ra_v = 0; rb_v = 0; ra_dr = 0; rb_dr = 0; ra_d = 0; rb_d = 0;
      for (int c = 0; c < 3000; c++) begin
         logic r;
         if (!ra_v && $urandom_range(0, 2) != 0) begin
            ra_v = 1; ra_dr = AW'($urandom_range(0, NREG-1)); ra_d = DW'($urandom);
         end
         if (!rb_v && $urandom_range(0, 2) != 0) begin
            rb_v = 1; rb_dr = AW'($urandom_range(0, NREG-1)); rb_d = DW'($urandom);
         end
         r = ($urandom_range(0, 199) != 0);
         step(r, ra_v, ra_dr, ra_d, rb_v, rb_dr, rb_d,
              1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG-1)),
              AW'($urandom_range(0, NREG-1)), AW'($urandom_range(0, NREG-1)));
         if (g_a) ra_v = 0;
         if (g_b) rb_v = 0;
      end
      idle(1); idle(1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Sequences the single write port (LD/DR/DR_IN) of the 8x16 register file and shares it between two writeback requesters: A is the ALU, B is memory/load.
- Round-robin grant with a valid/ready handshake, one write per cycle.
- Registered write outputs drive the register file directly.
- Holds a per-register busy scoreboard so the issue stage stalls on RAW/WAW hazards against writes still in flight.

Parameters:
NREG, 8, number of architectural registers
AW, 3, register index width (log2 NREG)
DW, 16, data width

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous reset, active-low
a_valid  input  1  requester A has a writeback
a_ready  output  1  A accepted this cycle (combinational)
a_dr  input  AW  A destination register
a_data  input  DW  A write data
b_valid  input  1  requester B has a writeback
b_ready  output  1  B accepted this cycle (combinational)
b_dr  input  AW  B destination register
b_data  input  DW  B write data
iss_valid  input  1  issue stage presents an instruction
iss_dr  input  AW  destination of the issuing instruction
iss_sr1  input  AW  source 1 of the issuing instruction
iss_sr2  input  AW  source 2 of the issuing instruction
iss_stall  output  1  issue blocked by hazard (combinational)
rf_ld  output  1  register file LD (registered)
rf_dr  output  AW  register file DR (registered)
rf_din  output  DW  register file DR_IN (registered)
busy  output  NREG  scoreboard, bit i = write pending to Ri (registered)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is synchronous, active-low.
- Reset values: rf_ld=0, rf_dr=0, rf_din=0, busy=0, last_grant=B, so A wins the first conflict.
- Grant, combinational:
  - Only A valid: A granted.
  - Only B valid: B granted.
  - Both valid: the requester not equal to last_grant is granted.
  - a_ready/b_ready equal the grant. At most one is high per cycle, and neither is high while rst_n=0.
- Accept edge (valid && ready): next cycle rf_ld=1 and rf_dr/rf_din take the winner's dr/data; last_grant updates to the winner.
- No accept: rf_ld=0. rf_dr/rf_din hold their previous values.
- Latency: accept at cycle N, register file write visible on rf_* during cycle N+1, data stored at the end of N+1.
- Throughput: one write per cycle, never idles while any request is valid.
- A request not granted stays pending. The requester must hold valid/dr/data stable until ready.
- Stall logic: iss_stall = iss_valid & (busy[iss_sr1] | busy[iss_sr2] | busy[iss_dr]). Both sources are always checked; no bypass, so a register being written in the current cycle still stalls.
- Scoreboard set: iss_valid && !iss_stall sets busy[iss_dr] at the edge.
- Scoreboard clear: rf_ld=1 clears busy[rf_dr] at the edge.
- Same register set and cleared on the same edge: set wins, busy stays 1.
- Different registers set and cleared on the same edge: both updates apply.
- A writeback to a register whose busy bit is 0 is still written. Busy stays 0; this is not an error.
- Reset mid-operation: pending rf_ld is dropped (forced 0), all busy bits cleared, last_grant returns to B. Requesters holding valid are arbitrated normally from the first cycle after reset deasserts.
- Index widths: all dr/sr indices are AW bits, so no out-of-range indices are possible.

Optional Feature:
- Macro: WB_CONFLICT_CNT_EN.
- Defined:
  - Adds output port conflict_cnt, 16 bits, reset 0.
  - Increments on every cycle with a_valid && b_valid && rst_n=1.
  - Saturates at 16'hFFFF.
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then A only: a_valid=1, a_dr=3, a_data=16'h1234 for one cycle -> a_ready=1 same cycle; next cycle rf_ld=1, rf_dr=3, rf_din=16'h1234; cycle after, rf_ld=0.
- Conflict fairness: A and B valid for 4 cycles (A: R1, 16'hAAAA; B: R2, 16'hBBBB), both held after acceptance -> grants alternate A,B,A,B; rf_dr sequence 1,2,1,2. With WB_CONFLICT_CNT_EN, conflict_cnt=4.
- Scoreboard RAW: issue dr=5 (busy[5]=1); next issue sr1=5 -> iss_stall=1. B writes R5 -> busy[5] clears at the end of the rf_ld cycle; the following cycle iss_stall=0.
- Set/clear collision: busy[4]=1 with rf_ld writing R4; same cycle issue dr=4 (sr1/sr2 not busy, so no stall) -> busy[4] stays 1 after the edge.
- WAW: busy[6]=1, issue dr=6 with sr1=0, sr2=0 -> iss_stall=1, busy unchanged.
- Reset mid-operation: A accepted, then rst_n=0 on the next cycle -> rf_ld=0, busy=0. With B valid and rst_n back to 1 -> b_ready=1 in that first cycle.
